rob_commit: RTL and testbench

- In-order reorder/commit buffer sitting downstream of `rename`.
- Consumes renamed instructions (`rinstr_t`), records execution write-backs by tag, and retires instructions in program order.
- Drives `p_commit` back to `rename` so the physical destination is marked ready/committed.
- Squashes wrong-path entries on a branch miss (`br_result_t`), consistent with the rename-side recovery.

---
 rtl/rob_commit_pkg.sv | 28 ++
 rtl/rob_oldest_branch.sv | 22 ++
 rtl/rob_commit.sv | 82 ++++++++
 tb/tb_rob_commit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared types for the reorder/commit buffer and its rename-side neighbours
package rob_commit_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } rd_t;
  typedef struct packed {
    logic valid;
    rd_t  rd;
    logic is_branch;
  } rinstr_t;
  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
    logic       ready;
  } p_reg_t;
  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;
  typedef struct packed {
    logic     valid;
    rob_tag_t tag;
  } wb_t;
endpackage

// File: rtl/rob_oldest_branch.sv
// rob_oldest_branch: finds the first candidate entry scanning forward from head, with wrap
module rob_oldest_branch #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0] head,
  input  logic [DEPTH-1:0] cand,
  output logic             found,
  output logic [TAG_W-1:0] index
);
  always_comb begin
    found = 1'b0;
    index = head;
    // scan youngest to oldest so the entry nearest head wins
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[head + TAG_W'(i)]) begin
        found = 1'b1;
        index = head + TAG_W'(i);
      end
    end
  end
endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer; tracks write-backs, resolves branches, retires to rename
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  rinstr_t          rinstr_i,
  output logic             rob_full_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  wb_t              wb_i,
  input  br_result_t       br_result_i,
  output p_reg_t           p_commit_o,
  output logic             rob_empty_o
);
  logic [TAG_W-1:0] head, tail, b_idx;
  logic [TAG_W:0]   count, count_n;
  logic [DEPTH-1:0] busy, done, brn, rdv, sq;
  logic [5:0]       rdi [DEPTH];
  logic             b_found, alloc, commit, resolve, miss, wb_ok;

  rob_oldest_branch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_find (
    .head (head),
    .cand (busy & brn & ~done),
    .found(b_found),
    .index(b_idx)
  );

  assign rob_full_o  = count == (TAG_W+1)'(DEPTH);
  assign rob_empty_o = count == '0;
  assign alloc_tag_o = tail;

  always_comb begin
    resolve = br_result_i.valid && b_found;
    miss    = resolve && !br_result_i.hit;
    alloc   = rinstr_i.valid && !rob_full_o && !miss;
    commit  = busy[head] && done[head];
    wb_ok   = wb_i.valid && busy[wb_i.tag] && !brn[wb_i.tag];
    // everything further from head than the missed branch is wrong-path
    for (int i = 0; i < DEPTH; i++) sq[i] = miss && (TAG_W'(i) - head > b_idx - head);
    count_n = miss ? {1'b0, b_idx - head} + (TAG_W+1)'(1) - (TAG_W+1)'(commit)
                   : count + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      busy       <= '0;
      done       <= '0;
      p_commit_o <= '0;
    end else begin
      head       <= head + TAG_W'(commit);
      tail       <= miss ? b_idx + TAG_W'(1) : tail + TAG_W'(alloc);
      count      <= count_n;
      p_commit_o <= commit ? '{valid: rdv[head], idx: rdi[head], ready: 1'b1} : '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && tail == TAG_W'(i)) begin
          busy[i] <= 1'b1;
          done[i] <= 1'b0;
        end else if ((commit && head == TAG_W'(i)) || sq[i]) begin
          busy[i] <= 1'b0;
          done[i] <= 1'b0;
        end else if ((resolve && b_idx == TAG_W'(i)) || (wb_ok && wb_i.tag == TAG_W'(i))) begin
          done[i] <= 1'b1;
        end
      end
    end
  end

  // payload is qualified by busy, so it needs no reset
  always_ff @(posedge clk) begin
    if (alloc) begin
      brn[tail] <= rinstr_i.is_branch;
      rdv[tail] <= rinstr_i.rd.valid;
      rdi[tail] <= rinstr_i.rd.idx;
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed checks of allocation, in-order commit, branch squash, wrap and async reset
module tb_rob_commit;
  import rob_commit_pkg::*;
  logic       clk = 1'b0;
  logic       rst_i;
  rinstr_t    rinstr_i;
  logic       rob_full_o, rob_empty_o;
  rob_tag_t   alloc_tag_o;
  wb_t        wb_i;
  br_result_t br_result_i;
  p_reg_t     p_commit_o;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .rinstr_i   (rinstr_i),
    .rob_full_o (rob_full_o),
    .alloc_tag_o(alloc_tag_o),
    .wb_i       (wb_i),
    .br_result_i(br_result_i),
    .p_commit_o (p_commit_o),
    .rob_empty_o(rob_empty_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int idx, input bit rdv, input bit br);
    rinstr_i.valid     = 1'b1;
    rinstr_i.rd.valid  = rdv;
    rinstr_i.rd.idx    = 6'(idx);
    rinstr_i.is_branch = br;
    tick;
    rinstr_i = '0;
    wb_i     = '0;
  endtask

  task automatic wb(input int tag);
    wb_i.valid = 1'b1;
    wb_i.tag   = rob_tag_t'(tag);
    tick;
    wb_i = '0;
  endtask

  task automatic reset_dut;
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
  endtask

  task automatic check_pc(input string tag, input bit v, input int idx);
    check({tag, ".valid"}, int'(p_commit_o.valid), int'(v));
    check({tag, ".ready"}, int'(p_commit_o.ready), 1);
    if (v) check({tag, ".idx"}, int'(p_commit_o.idx), idx);
  endtask

  task automatic branch_setup;
    reset_dut;
    alloc(10, 1'b1, 1'b0);
    alloc(11, 1'b0, 1'b1);
    alloc(12, 1'b1, 1'b0);
    alloc(13, 1'b1, 1'b0);
    wb(2);
    wb(3);
  endtask

  initial begin
    rinstr_i = '0;
    wb_i = '0;
    br_result_i = '0;
    rst_i = 1'b1;
    #2;
    check("rst.empty", int'(rob_empty_o), 1);
    check("rst.full", int'(rob_full_o), 0);
    check("rst.tag", int'(alloc_tag_o), 0);
    check("rst.pc", int'(p_commit_o), 0);
    rst_i = 1'b0;

    // three allocations written back in reverse order
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1.tag%0d", i), int'(alloc_tag_o), i);
      alloc(32 + i, 1'b1, 1'b0);
    end
    wb(2);
    wb(1);
    wb(0);
    check("t1.pc_early", int'(p_commit_o.valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check_pc($sformatf("t1.c%0d", i), 1'b1, 32 + i);
    end
    tick;
    check("t1.pc_idle", int'(p_commit_o.valid), 0);
    check("t1.empty", int'(rob_empty_o), 1);

    // fill, overflow attempt, wrap
    reset_dut;
    for (int i = 0; i < 16; i++) alloc(i, 1'b1, 1'b0);
    check("t2.full", int'(rob_full_o), 1);
    check("t2.count", int'(dut.count), 16);
    check("t2.tag", int'(alloc_tag_o), 0);
    alloc(63, 1'b1, 1'b0);
    check("t2.ovf_count", int'(dut.count), 16);
    check("t2.ovf_tag", int'(alloc_tag_o), 0);
    wb(0);
    check("t2.full_wb", int'(rob_full_o), 1);
    tick;
    check("t2.full_after", int'(rob_full_o), 0);
    check_pc("t2.c0", 1'b1, 0);
    check("t2.wrap_tag", int'(alloc_tag_o), 0);
    alloc(40, 1'b1, 1'b0);
    check("t2.refull", int'(rob_full_o), 1);

    // branch miss squashes C and D
    branch_setup;
    br_result_i = '{valid: 1'b1, hit: 1'b0};
    tick;
    br_result_i = '0;
    check("t3.tail", int'(alloc_tag_o), 2);
    check("t3.count", int'(dut.count), 2);
    wb(3);
    check("t3.count_wb", int'(dut.count), 2);
    wb(0);
    tick;
    check_pc("t3.cA", 1'b1, 10);
    tick;
    check_pc("t3.cB", 1'b0, 0);
    tick;
    check("t3.pc_idle", int'(p_commit_o.valid), 0);
    check("t3.empty", int'(rob_empty_o), 1);

    // branch hit keeps all four
    branch_setup;
    br_result_i = '{valid: 1'b1, hit: 1'b1};
    tick;
    br_result_i = '0;
    check("t4.tail", int'(alloc_tag_o), 4);
    check("t4.count", int'(dut.count), 4);
    wb(0);
    tick;
    check_pc("t4.cA", 1'b1, 10);
    tick;
    check_pc("t4.cB", 1'b0, 0);
    tick;
    check_pc("t4.cC", 1'b1, 12);
    tick;
    check_pc("t4.cD", 1'b1, 13);
    tick;
    check("t4.empty", int'(rob_empty_o), 1);

    // allocate and commit on the same edge
    reset_dut;
    for (int i = 0; i < 5; i++) alloc(20 + i, 1'b1, 1'b0);
    wb(0);
    check("t5.count_pre", int'(dut.count), 5);
    alloc(25, 1'b1, 1'b0);
    check("t5.count", int'(dut.count), 5);
    check_pc("t5.c0", 1'b1, 20);
    check("t5.tag", int'(alloc_tag_o), 6);

    // async reset with 7 busy entries
    alloc(26, 1'b1, 1'b0);
    wb_i = '{valid: 1'b1, tag: rob_tag_t'(1)};
    alloc(27, 1'b1, 1'b0);
    alloc(28, 1'b1, 1'b0);
    check("t6.count", int'(dut.count), 7);
    check_pc("t6.c1", 1'b1, 21);
    #1;
    rst_i = 1'b1;
    #1;
    check("t6.empty", int'(rob_empty_o), 1);
    check("t6.full", int'(rob_full_o), 0);
    check("t6.tag", int'(alloc_tag_o), 0);
    check("t6.pc", int'(p_commit_o), 0);
    check("t6.count_rst", int'(dut.count), 0);
    rst_i = 1'b0;
    alloc(30, 1'b1, 1'b0);
    check("t6.tag_next", int'(alloc_tag_o), 1);
    check("t6.count_next", int'(dut.count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
